inst_cache: RTL and testbench

- Direct-mapped, read-only instruction cache that sits directly upstream of the instruction fetcher.
- Accepts one word-address lookup at a time from the fetcher and returns the 32-bit instruction with a one-cycle done pulse.
- On a miss, fills a full line from the memory controller one word at a time, then responds.

---
 rtl/icache_pkg.sv | 36 +++
 rtl/icache_array.sv | 47 ++++
 rtl/inst_cache.sv | 180 ++++++++++++++++++
 tb/tb_inst_cache.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, derived widths and address helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int INST_WIDTH   = 32;
    localparam int INDEX_WIDTH  = 6;
    localparam int OFFSET_WIDTH = 2;

    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;
    localparam int LINE_WORDS = 1 << OFFSET_WIDTH;
    localparam int NUM_LINES  = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_FILL    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // Word address (byte-select bits stripped) split into its cache fields.
    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [INDEX_WIDTH-1:0]  index;
        logic [OFFSET_WIDTH-1:0] offset;
    } word_addr_t;

    function automatic word_addr_t split_addr(input logic [ADDR_WIDTH-3:0] word_addr);
        return word_addr_t'(word_addr);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [TAG_WIDTH-1:0]   tag,
                                                        input logic [INDEX_WIDTH-1:0] index);
        return {tag, index, {(OFFSET_WIDTH + 2){1'b0}}};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: one word-granular write port with a line commit strobe,
// one combinational read port, valid bits cleared by async reset.
module icache_array
    import icache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [INDEX_WIDTH-1:0]  wr_index,
    input  logic [OFFSET_WIDTH-1:0] wr_offset,
    input  logic [INST_WIDTH-1:0]   wr_data,
    input  logic                    commit,
    input  logic [TAG_WIDTH-1:0]    commit_tag,
    input  logic [INDEX_WIDTH-1:0]  rd_index,
    input  logic [OFFSET_WIDTH-1:0] rd_offset,
    output logic                    rd_valid,
    output logic [TAG_WIDTH-1:0]    rd_tag,
    output logic [INST_WIDTH-1:0]   rd_data
);

    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
    logic [INST_WIDTH-1:0] data_mem [NUM_LINES * LINE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (commit) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; contents are meaningless until the valid bit says otherwise.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (commit) begin
            tag_mem[wr_index] <= commit_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with single-outstanding line fill.
// Optional ICACHE_PERF_EN adds wrapping hit/miss counters on COMPARE outcomes.
module inst_cache
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  inst_cache_read_valid,
    input  logic [ADDR_WIDTH-1:0] inst_cache_read_addr,
    output logic                  inst_cache_read_done,
    output logic [INST_WIDTH-1:0] inst_cache_read_data,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic                  mem_read_done,
    input  logic [INST_WIDTH-1:0] mem_read_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]           perf_hit_count,
    output logic [31:0]           perf_miss_count
`endif
);

    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(LINE_WORDS - 1);

    state_t                  state, state_n;
    word_addr_t              req, req_n;
    logic [OFFSET_WIDTH-1:0] cnt, cnt_n;
    logic                    flush_pend, flush_pend_n;
    logic [INST_WIDTH-1:0]   resp_word, resp_word_n;
    logic                    done_n;
    logic [INST_WIDTH-1:0]   data_n;
    logic                    mem_valid_n;
    logic [ADDR_WIDTH-1:0]   mem_addr_n;
    logic                    wr_en, commit;
    logic                    arr_valid;
    logic [TAG_WIDTH-1:0]    arr_tag;
    logic [INST_WIDTH-1:0]   arr_data;
    logic                    hit;
    logic                    unused_byte_bits;

    assign unused_byte_bits = ^inst_cache_read_addr[1:0];
    assign hit = arr_valid && (arr_tag == req.tag);

    icache_array u_array (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en && rdy),
        .wr_index   (req.index),
        .wr_offset  (cnt),
        .wr_data    (mem_read_data),
        .commit     (commit && rdy),
        .commit_tag (req.tag),
        .rd_index   (req.index),
        .rd_offset  (req.offset),
        .rd_valid   (arr_valid),
        .rd_tag     (arr_tag),
        .rd_data    (arr_data)
    );

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_n      = state;
        req_n        = req;
        cnt_n        = cnt;
        flush_pend_n = flush_pend;
        resp_word_n  = resp_word;
        done_n       = 1'b0;
        data_n       = inst_cache_read_data;
        mem_valid_n  = mem_read_valid;
        mem_addr_n   = mem_read_addr;
        wr_en        = 1'b0;
        commit       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                flush_pend_n = 1'b0;
                if (inst_cache_read_valid && !flush) begin
                    req_n   = split_addr(inst_cache_read_addr[ADDR_WIDTH-1:2]);
                    state_n = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else if (hit) begin
                    done_n  = 1'b1;
                    data_n  = arr_data;
                    state_n = ST_IDLE;
                end else begin
                    mem_valid_n = 1'b1;
                    mem_addr_n  = line_base(req.tag, req.index);
                    cnt_n       = '0;
                    state_n     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (flush) begin
                    flush_pend_n = 1'b1;
                end
                if (mem_read_valid && mem_read_done) begin
                    wr_en = 1'b1;
                    cnt_n = cnt + 1'b1;
                    // Keep the requested word aside so RESPOND needs no array read.
                    if (cnt == req.offset) begin
                        resp_word_n = mem_read_data;
                    end
                    if (cnt == LAST_WORD) begin
                        mem_valid_n = 1'b0;
                        commit      = 1'b1;
                        state_n     = ST_RESPOND;
                    end else begin
                        mem_addr_n = mem_read_addr + ADDR_WIDTH'(4);
                    end
                end
            end
            ST_RESPOND: begin
                if (!flush && !flush_pend) begin
                    done_n = 1'b1;
                    data_n = resp_word;
                end
                flush_pend_n = 1'b0;
                state_n      = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_n;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req                  <= '0;
            cnt                  <= '0;
            flush_pend           <= 1'b0;
            resp_word            <= '0;
            inst_cache_read_done <= 1'b0;
            inst_cache_read_data <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_addr        <= '0;
        end else if (rdy) begin
            req                  <= req_n;
            cnt                  <= cnt_n;
            flush_pend           <= flush_pend_n;
            resp_word            <= resp_word_n;
            inst_cache_read_done <= done_n;
            inst_cache_read_data <= data_n;
            mem_read_valid       <= mem_valid_n;
            mem_read_addr        <= mem_addr_n;
        end
    end

`ifdef ICACHE_PERF_EN
    // Every COMPARE lookup is classified, even when a flush discards it.
    logic lookup;
    assign lookup = rdy && (state == ST_COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_count  <= '0;
            perf_miss_count <= '0;
        end else if (lookup) begin
            if (hit) begin
                perf_hit_count <= perf_hit_count + 32'd1;
            end else begin
                perf_miss_count <= perf_miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: random and directed fetches against a set-indexed memory model.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        read_valid;
    logic [31:0] read_addr;
    logic        read_done;
    logic [31:0] read_data;
    logic        mem_read_valid;
    logic [31:0] mem_read_addr;
    logic        mem_read_done;
    logic [31:0] mem_read_data;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_count;
    logic [31:0] perf_miss_count;
`endif

    inst_cache dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .flush                 (flush),
        .inst_cache_read_valid (read_valid),
        .inst_cache_read_addr  (read_addr),
        .inst_cache_read_done  (read_done),
        .inst_cache_read_data  (read_data),
        .mem_read_valid        (mem_read_valid),
        .mem_read_addr         (mem_read_addr),
        .mem_read_done         (mem_read_done),
        .mem_read_data         (mem_read_data)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit_count        (perf_hit_count),
        .perf_miss_count       (perf_miss_count)
`endif
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] seed;
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_addr_q[$];
    bit          model_valid[64];
    int unsigned model_tag[64];
    int          model_hits = 0;
    int          model_misses = 0;
    bit          stall_en = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic int line_index(input logic [31:0] a);
        return int'((a >> 4) % 64);
    endfunction

    function automatic int unsigned line_tag(input logic [31:0] a);
        return int'(a >> 10);
    endfunction

    task automatic model_invalidate();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    task automatic expect_fill(input logic [31:0] a);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back((a & 32'hFFFF_FFF0) + 32'(4 * i));
        model_valid[line_index(a)] = 1'b1;
        model_tag[line_index(a)]   = line_tag(a);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (!rst && read_done) begin
            if (exp_data_q.size() == 0) check("unexpected_done", 1, 0);
            else check("read_data", read_data, exp_data_q.pop_front());
        end
    end

    // Memory controller model; also owns rdy so stalls land inside a fill.
    initial begin : responder
        int          words_in_fill = 0;
        int          stall_left = 0;
        bit          stalled = 1'b0;
        logic [31:0] stall_addr = '0;
        rdy = 1'b1;
        mem_read_done = 1'b0;
        mem_read_data = '0;
        forever begin
            @(negedge clk);
            if (rst || !mem_read_valid) begin
                mem_read_done = 1'b0;
                rdy = 1'b1;
                words_in_fill = 0;
                stalled = 1'b0;
            end else begin
                if (stall_left > 0) begin
                    check("stall_addr_hold", mem_read_addr, stall_addr);
                    stall_left--;
                end else if (stall_en && !stalled && words_in_fill == 1) begin
                    stalled = 1'b1;
                    stall_left = 5;
                    stall_addr = mem_read_addr;
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    mem_read_done = 1'b1;
                    mem_read_data = 32'hDEAD_BEEF;
                end else begin
                    rdy = 1'b1;
                    if ($urandom_range(0, 3) != 0) begin
                        if (exp_addr_q.size() == 0) check("unexpected_mem_req", 1, 0);
                        else check("mem_addr", mem_read_addr, exp_addr_q.pop_front());
                        mem_read_done = 1'b1;
                        mem_read_data = mem_fn(mem_read_addr);
                        words_in_fill++;
                    end else begin
                        mem_read_done = 1'b0;
                    end
                end
            end
        end
    end

    // Caller is always 1 time unit after a posedge; returns the same way.
    task automatic do_req(input logic [31:0] a, input bit flush_cmp);
        bit hit;
        int n;
        hit = model_valid[line_index(a)] && (model_tag[line_index(a)] == line_tag(a));
        if (hit) model_hits++;
        else model_misses++;
        read_valid = 1'b1;
        read_addr  = a;
        @(posedge clk); #1;
        read_valid = 1'b0;
        if (flush_cmp) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            check("cmp_flush_no_done", read_done, 0);
            check("cmp_flush_no_mem", mem_read_valid, 0);
            repeat (2) @(posedge clk);
            #1;
            return;
        end
        exp_data_q.push_back(mem_fn(a & 32'hFFFF_FFFC));
        if (hit) begin
            @(posedge clk); #1;
            check("hit_latency", read_done, 1);
            check("hit_no_mem", mem_read_valid, 0);
        end else begin
            expect_fill(a);
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!read_done && n < 400);
            check("miss_done", read_done, 1);
        end
    endtask

    task automatic wait_addr_left(input int left);
        int n = 0;
        while (exp_addr_q.size() > left && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("fill_progress", exp_addr_q.size() <= left, 1);
    endtask

    task automatic fill_with_flush(input logic [31:0] a);
        int n = 0;
        model_misses++;
        read_valid = 1'b1;
        read_addr  = a;
        @(posedge clk); #1;
        read_valid = 1'b0;
        expect_fill(a);
        wait_addr_left(2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        while ((mem_read_valid || exp_addr_q.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("flush_fill_all_words", exp_addr_q.size(), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("flush_fill_no_done", read_done, 0);
        end
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        read_valid = 1'b1;
        read_addr  = a;
        @(posedge clk); #1;
        read_valid = 1'b0;
        expect_fill(a);
        wait_addr_left(2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mem_valid_drop", mem_read_valid, 0);
        check("rst_done_low", read_done, 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        model_invalidate();
        model_hits = 0;
        model_misses = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_flush(input logic [31:0] a);
        read_valid = 1'b1;
        flush      = 1'b1;
        read_addr  = a;
        @(posedge clk); #1;
        read_valid = 1'b0;
        flush      = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_flush_no_mem", mem_read_valid, 0);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] a;
        seed       = $urandom;
        rst        = 1'b0;
        flush      = 1'b0;
        read_valid = 1'b0;
        read_addr  = '0;
        model_invalidate();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", read_done, 0);
        check("reset_data", read_data, 0);
        check("reset_mem_valid", mem_read_valid, 0);
        check("reset_mem_addr", mem_read_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(32'h0000_0100, 1'b0);
        do_req(32'h0000_0104, 1'b0);
        do_req(32'h0000_0000, 1'b0);
        do_req(32'h0000_0400, 1'b0);
        do_req(32'h0000_0000, 1'b0);

        fill_with_flush(32'h0000_0800);
        do_req(32'h0000_0808, 1'b0);

        stall_en = 1'b1;
        do_req(32'h0000_1230, 1'b0);
        stall_en = 1'b0;
        do_req(32'h0000_1234, 1'b0);

        reset_mid_fill(32'h0000_2040);
        do_req(32'h0000_2040, 1'b0);

        idle_flush(32'h0000_3000);
        do_req(32'h0000_3000, 1'b0);

        for (int i = 0; i < 200; i++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            do_req(a, $urandom_range(0, 9) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("data_queue_drained", exp_data_q.size(), 0);
        check("addr_queue_drained", exp_addr_q.size(), 0);
`ifdef ICACHE_PERF_EN
        check("perf_hit_count", perf_hit_count, model_hits);
        check("perf_miss_count", perf_miss_count, model_misses);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
